mem_bist_ctrl: RTL

Built-in self-test initiator for the single-port synchronous memory block. It drives that memory's clk/wr/addr/din port and reads dout back. On start it runs a 4-phase march: write pattern, read/compare, write inverse, read/compare inverse. It reports pass/fail and captures the first failing address and data, and sits between the test/debug register file and the memory instance.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_bist_cmp.sv | 67 ++++++
 rtl/mem_bist_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and data-pattern helper for the memory BIST controller
//
// Contents:
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH  default geometry of the memory under test
//   PAT_BASE                         ...1010 background pattern, truncated by the user
//   bist_state_t                     march sequencer states
//   pat_data(addr, pat, inv)         D(a) = a XOR pat, or ~D(a) when inv=1 (32-bit,
//                                    caller truncates to DATA_WIDTH)
package mem_pkg;

    localparam int DEF_DATA_WIDTH = 2;
    localparam int DEF_ADDR_WIDTH = 2;
    localparam logic [31:0] PAT_BASE = 32'hAAAA_AAAA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W0,
        ST_R0,
        ST_W1,
        ST_R1,
        ST_CHECK,
        ST_DONE
    } bist_state_t;

    // Mixing the address into the data gives each word a distinct value
    // (where the width allows) so aliased addresses show up as mismatches.
    function automatic logic [31:0] pat_data(input logic [31:0] addr,
                                             input logic [31:0] pat,
                                             input logic        inv);
        return (addr ^ pat) ^ {32{inv}};
    endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// rtl/mem_bist_cmp.sv - read-compare pipeline stage and first-failure capture
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clr            clears the capture registers (new test accepted)
//   rd_issue       a read is presented to the memory this cycle
//   rd_addr/rd_exp address and expected word of that read
//   mem_dout       memory read data (valid the cycle after the read)
//   mismatch       compare failed this cycle
//   fail_addr/exp/act  captured address, expected and actual word of the first mismatch
module mem_bist_cmp #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  rd_issue,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_exp,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  mismatch,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_act
);

    logic                  chk_vld;
    logic [ADDR_WIDTH-1:0] chk_addr;
    logic [DATA_WIDTH-1:0] chk_exp;
    logic                  fail_seen;

    assign mismatch = chk_vld && (mem_dout != chk_exp);

    // A mismatch aborts the test, so no further compare is armed behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_vld  <= 1'b0;
            chk_addr <= '0;
            chk_exp  <= '0;
        end else begin
            chk_vld  <= rd_issue && !mismatch && !clr;
            chk_addr <= rd_addr;
            chk_exp  <= rd_exp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_seen <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
        end else if (clr) begin
            fail_seen <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_act  <= '0;
        end else if (mismatch && !fail_seen) begin
            fail_seen <= 1'b1;
            fail_addr <= chk_addr;
            fail_exp  <= chk_exp;
            fail_act  <= mem_dout;
        end
    end

endmodule

// File: rtl/mem_bist_ctrl.sv
// rtl/mem_bist_ctrl.sv - 4-phase march BIST initiator for a single-port synchronous memory
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      test request, sampled only in IDLE
//   busy                       test in progress (through the DONE cycle)
//   done                       one-cycle end-of-test pulse
//   pass                       result, held until the next accepted start
//   fail_addr/fail_exp/fail_act  first mismatch: address, expected word, read word
//   mem_wr/mem_addr/mem_din    registered memory command
//   mem_dout                   memory read data
module mem_bist_ctrl
    import mem_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    MEM_DEPTH  = 1 << ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = DATA_WIDTH'(PAT_BASE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_act,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    bist_state_t           state, state_nx;
    logic                  mem_wr_nx;
    logic [ADDR_WIDTH-1:0] mem_addr_nx;
    logic [DATA_WIDTH-1:0] mem_din_nx;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic                  accept;
    logic                  rd_issue;
    logic [DATA_WIDTH-1:0] rd_exp;
    logic                  mismatch;

    function automatic logic [DATA_WIDTH-1:0] d_of(input logic [ADDR_WIDTH-1:0] a,
                                                   input logic inv);
        return DATA_WIDTH'(pat_data(32'(a), 32'(PATTERN), inv));
    endfunction

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign addr_inc = mem_addr + ADDR_WIDTH'(1);
    assign rd_issue = (state == ST_R0) || (state == ST_R1);
    assign rd_exp   = d_of(mem_addr, state == ST_R1);

    // The memory command for the next cycle is computed alongside the next
    // state, so the registered mem_* always belongs to the current state.
    // Phase changes decode the terminal address, never counter overflow.
    always_comb begin
        state_nx    = state;
        mem_wr_nx   = 1'b0;
        mem_addr_nx = mem_addr;
        mem_din_nx  = mem_din;
        accept      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    accept      = 1'b1;
                    state_nx    = ST_W0;
                    mem_wr_nx   = 1'b1;
                    mem_addr_nx = '0;
                    mem_din_nx  = d_of('0, 1'b0);
                end
            end
            ST_W0: begin
                if (mem_addr == LAST_ADDR) begin
                    state_nx    = ST_R0;
                    mem_addr_nx = '0;
                end else begin
                    mem_wr_nx   = 1'b1;
                    mem_addr_nx = addr_inc;
                    mem_din_nx  = d_of(addr_inc, 1'b0);
                end
            end
            ST_R0: begin
                if (mem_addr == LAST_ADDR) begin
                    state_nx    = ST_W1;
                    mem_wr_nx   = 1'b1;
                    mem_addr_nx = '0;
                    mem_din_nx  = d_of('0, 1'b1);
                end else begin
                    mem_addr_nx = addr_inc;
                end
            end
            ST_W1: begin
                if (mem_addr == LAST_ADDR) begin
                    state_nx    = ST_R1;
                    mem_addr_nx = LAST_ADDR;
                end else begin
                    mem_wr_nx   = 1'b1;
                    mem_addr_nx = addr_inc;
                    mem_din_nx  = d_of(addr_inc, 1'b1);
                end
            end
            ST_R1: begin
                if (mem_addr == '0) begin
                    state_nx = ST_CHECK;
                end else begin
                    mem_addr_nx = mem_addr - ADDR_WIDTH'(1);
                end
            end
            ST_CHECK: state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        // First mismatch aborts straight to DONE with the memory left idle.
        if (mismatch) begin
            state_nx  = ST_DONE;
            mem_wr_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            state    <= state_nx;
            mem_wr   <= mem_wr_nx;
            mem_addr <= mem_addr_nx;
            mem_din  <= mem_din_nx;
        end
    end

    // pass is only ever set by a clean final compare in CHECK; an abort
    // leaves it at the 0 written on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass <= 1'b0;
        end else if (accept) begin
            pass <= 1'b0;
        end else if (state == ST_CHECK && !mismatch) begin
            pass <= 1'b1;
        end
    end

    mem_bist_cmp #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_cmp (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept),
        .rd_issue (rd_issue),
        .rd_addr  (mem_addr),
        .rd_exp   (rd_exp),
        .mem_dout (mem_dout),
        .mismatch (mismatch),
        .fail_addr(fail_addr),
        .fail_exp (fail_exp),
        .fail_act (fail_act)
    );

endmodule
